// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Raster timing generator. Owns the horizontal and vertical pixel
//            counters and decodes sync, blanking and line/frame strobes from
//            them. Every output is registered and aligned with the counters
//            presented in the same cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1      pixel-domain clock
//   rst          in   1      synchronous active-high reset
//   ce           in   1      advance enable (only with VIDEO_TIMING_CE_EN)
//   hcount       out  WIDTH  horizontal position
//   vcount       out  WIDTH  vertical position
//   hsync        out  1      horizontal sync, asserted level H_POL
//   vsync        out  1      vertical sync, asserted level V_POL
//   blank        out  1      high outside the active area
//   active       out  1      inverse of blank
//   line_start   out  1      high while hcount = 0
//   frame_start  out  1      high while (hcount, vcount) = (0, 0)
// Build option:
//   VIDEO_TIMING_CE_EN  - adds the ce port; the block advances only on clock
//                         edges with ce = 1. Undefined: advances every edge.
// ============================================================================
module video_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1,
    parameter int   WIDTH    = 11
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VIDEO_TIMING_CE_EN
    input  logic             ce,
`endif
    output logic [WIDTH-1:0] hcount,
    output logic [WIDTH-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
);

    // Region boundaries, resolved at elaboration. Sync ends are exclusive;
    // a back porch of at least one keeps them representable in WIDTH bits.
    localparam int               c_H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int               c_V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [WIDTH-1:0] c_ZERO         = WIDTH'(0);
    localparam logic [WIDTH-1:0] c_ONE          = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_H_LAST       = WIDTH'(c_H_TOTAL - 1);
    localparam logic [WIDTH-1:0] c_V_LAST       = WIDTH'(c_V_TOTAL - 1);
    localparam logic [WIDTH-1:0] c_H_ACT        = WIDTH'(H_ACTIVE);
    localparam logic [WIDTH-1:0] c_V_ACT        = WIDTH'(V_ACTIVE);
    localparam logic [WIDTH-1:0] c_H_SYNC_START = WIDTH'(H_ACTIVE + H_FP);
    localparam logic [WIDTH-1:0] c_H_SYNC_END   = WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [WIDTH-1:0] c_V_SYNC_START = WIDTH'(V_ACTIVE + V_FP);
    localparam logic [WIDTH-1:0] c_V_SYNC_END   = WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    logic             w_advance;
    logic             w_h_wrap;

    logic [WIDTH-1:0] hcount_q, hcount_d;
    logic [WIDTH-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             blank_q, blank_d;
    logic             active_q, active_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

`ifdef VIDEO_TIMING_CE_EN
    assign w_advance = ce;
`else
    assign w_advance = 1'b1;
`endif

    // Next position and its decode. The decode looks at the next-state
    // counters so the registered flags line up with the registered counters.
    always_comb begin
        w_h_wrap = (hcount_q == c_H_LAST);
        hcount_d = w_h_wrap ? c_ZERO : hcount_q + c_ONE;
        vcount_d = vcount_q;
        if (w_h_wrap) begin
            vcount_d = (vcount_q == c_V_LAST) ? c_ZERO : vcount_q + c_ONE;
        end

        hsync_d       = ((hcount_d >= c_H_SYNC_START) && (hcount_d < c_H_SYNC_END))
                        ? H_POL : ~H_POL;
        vsync_d       = ((vcount_d >= c_V_SYNC_START) && (vcount_d < c_V_SYNC_END))
                        ? V_POL : ~V_POL;
        blank_d       = (hcount_d >= c_H_ACT) || (vcount_d >= c_V_ACT);
        active_d      = ~blank_d;
        line_start_d  = (hcount_d == c_ZERO);
        frame_start_d = (hcount_d == c_ZERO) && (vcount_d == c_ZERO);
    end

    // Reset parks the raster on its last back-porch position, so the first
    // advance lands on (0, 0). Reset takes priority over a held advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= c_H_LAST;
            vcount_q      <= c_V_LAST;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            blank_q       <= 1'b1;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (w_advance) begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Self-checking bench for video_timing_gen. Two instances run side
//            by side: a small raster with both sync polarities low (whole
//            frames, vertical decode, frame period) and the default 800x600
//            raster (reset values, line decode, line wrap). The reference
//            model tracks a linear raster position per instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    // Small raster
    localparam int SHA = 16, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 2;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam int ST  = SHT * SVT;
    localparam int SW  = 8;
    // Default raster
    localparam int DHA = 800, DHF = 40, DHS = 128, DHB = 88;
    localparam int DVA = 600, DVF = 1,  DVS = 4,   DVB = 23;
    localparam int DT  = (DHA + DHF + DHS + DHB) * (DVA + DVF + DVS + DVB);

`ifdef VIDEO_TIMING_CE_EN
    localparam bit CE_EN = 1'b1;
`else
    localparam bit CE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;
    always #5 clk = ~clk;

    logic [SW-1:0] s_hcount, s_vcount;
    logic          s_hsync, s_vsync, s_blank, s_active, s_line_start, s_frame_start;
    logic [10:0]   d_hcount, d_vcount;
    logic          d_hsync, d_vsync, d_blank, d_active, d_line_start, d_frame_start;

    video_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .H_POL(1'b0), .V_POL(1'b0), .WIDTH(SW)
    ) u_small (
        .clk(clk), .rst(rst),
`ifdef VIDEO_TIMING_CE_EN
        .ce(ce),
`endif
        .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
        .blank(s_blank), .active(s_active), .line_start(s_line_start),
        .frame_start(s_frame_start)
    );

    video_timing_gen u_dflt (
        .clk(clk), .rst(rst),
`ifdef VIDEO_TIMING_CE_EN
        .ce(ce),
`endif
        .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
        .blank(d_blank), .active(d_active), .line_start(d_line_start),
        .frame_start(d_frame_start)
    );

    // Expected raster positions after a clock edge, plus what drove it.
    typedef struct {
        int sk;
        int dk;
        bit adv;
        bit r;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   sk = ST - 1;
    int   dk = DT - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode of a linear raster position k into the output set.
    task automatic decode(input int k, input int ha, input int hf, input int hs, input int hb,
                          input int va, input int vf, input int vs, input int vb,
                          input bit hp, input bit vp,
                          output int h, output int v, output bit o_hs, output bit o_vs,
                          output bit o_bl, output bit o_ls, output bit o_fs);
        int ht;
        ht   = ha + hf + hs + hb;
        h    = k % ht;
        v    = k / ht;
        o_hs = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
        o_vs = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
        o_bl = (h >= ha) || (v >= va);
        o_ls = (h == 0);
        o_fs = (k == 0);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the model's
    // expectation for the following rising edge.
    task automatic step(input bit r, input bit c);
        exp_t e;
        bit   adv;
        rst = r;
        ce  = c;
        adv = !r && (CE_EN ? c : 1'b1);
        if (r) begin
            sk = ST - 1;
            dk = DT - 1;
        end else if (adv) begin
            sk = (sk + 1) % ST;
            dk = (dk + 1) % DT;
        end
        e.sk  = sk;
        e.dk  = dk;
        e.adv = adv;
        e.r   = r;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares every presented cycle against the queued model.
    int s_adv_cnt  = 0;
    bit s_fs_seen  = 1'b0;
    initial begin
        exp_t e;
        int   h, v;
        bit   hs, vs, bl, ls, fs;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                decode(e.sk, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, 1'b0,
                       h, v, hs, vs, bl, ls, fs);
                chk("s_hcount",      32'(s_hcount),      32'(h));
                chk("s_vcount",      32'(s_vcount),      32'(v));
                chk("s_hsync",       32'(s_hsync),       32'(hs));
                chk("s_vsync",       32'(s_vsync),       32'(vs));
                chk("s_blank",       32'(s_blank),       32'(bl));
                chk("s_active",      32'(s_active),      32'(!bl));
                chk("s_line_start",  32'(s_line_start),  32'(ls));
                chk("s_frame_start", 32'(s_frame_start), 32'(fs));
                decode(e.dk, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1, 1'b1,
                       h, v, hs, vs, bl, ls, fs);
                chk("d_hcount",      32'(d_hcount),      32'(h));
                chk("d_vcount",      32'(d_vcount),      32'(v));
                chk("d_hsync",       32'(d_hsync),       32'(hs));
                chk("d_vsync",       32'(d_vsync),       32'(vs));
                chk("d_blank",       32'(d_blank),       32'(bl));
                chk("d_active",      32'(d_active),      32'(!bl));
                chk("d_line_start",  32'(d_line_start),  32'(ls));
                chk("d_frame_start", 32'(d_frame_start), 32'(fs));
                // Frame period measured in advances between frame_start pulses.
                if (e.r) begin
                    s_fs_seen = 1'b0;
                    s_adv_cnt = 0;
                end else if (e.adv) begin
                    s_adv_cnt++;
                    if (s_frame_start === 1'b1) begin
                        if (s_fs_seen) chk("s_frame_period", 32'(s_adv_cnt), 32'(ST));
                        s_fs_seen = 1'b1;
                        s_adv_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
        // Free running: three small frames.
        for (int i = 0; i < 3 * ST; i++) step(1'b0, 1'b1);
        // Enable every fourth cycle: two small frames.
        for (int i = 0; i < 8 * ST; i++) step(1'b0, (i % 4) == 3);
        // Random enable with occasional resets.
        for (int i = 0; i < 800; i++)
            step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)));
        // Reset mid-line while the enable is low.
        for (int i = 0; i < 37; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, 1'($urandom_range(0, 1)));
        // Clean restart and run past two default line wraps.
        step(1'b1, 1'b1);
        for (int i = 0; i < 2200; i++) step(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator that produces the horizontal and vertical counters, sync pulses, blanking and frame/line strobes for the video pipeline. It supersedes the per-signal combinational sync decoders: one block now owns both counters, all porch/sync region decode, and sync polarity. All outputs are registered and mutually aligned. The block sits at the head of the video bus, and the pixel generators and sprite/overlay logic consume its outputs.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels), must be ≥ 1
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines), must be ≥ 1
- H_POL, 1, asserted level of hsync (1 = active-high)
- V_POL, 1, asserted level of vsync
- WIDTH, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- ce  in  1  advance enable (only with VIDEO_TIMING_CE_EN)
- hcount  out  WIDTH  horizontal position
- vcount  out  WIDTH  vertical position
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- blank  out  1  high outside the active area
- active  out  1  equals ~blank
- line_start  out  1  one-cycle strobe at hcount = 0
- frame_start  out  1  one-cycle strobe at (hcount, vcount) = (0, 0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL likewise (628).
- Horizontal region order: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. The vertical order is the same.
- hcount increments on each advance and wraps H_TOTAL-1 → 0. On that wrap, vcount increments and wraps V_TOTAL-1 → 0. vcount holds otherwise.
- hsync = H_POL inside the horizontal sync range, ~H_POL elsewhere. vsync = V_POL inside the vertical sync range (whole lines, changing with the vcount update), ~V_POL elsewhere.
- blank = 1 when hcount ≥ H_ACTIVE or vcount ≥ V_ACTIVE.
- line_start = 1 when hcount = 0. frame_start = 1 when both counters are 0.
- Decode uses the next-state counter values and is registered, so every output corresponds to the hcount/vcount presented in the same cycle. There is no extra pipeline skew.
- Counter arithmetic is unsigned WIDTH bits. Compare limits are computed from parameters at elaboration.

## Timing
- Reset values: hcount = H_TOTAL-1, vcount = V_TOTAL-1, hsync = ~H_POL, vsync = ~V_POL, blank = 1, active = 0, line_start = 0, frame_start = 0. These are the decoded values of the last back-porch position.
- First advance after rst deasserts: hcount = 0, vcount = 0, frame_start = line_start = 1, active = 1.
- rst asserted mid-frame: outputs take the reset values on the next clk edge, regardless of ce.
- Output latency is 0 relative to the counters. Each output changes only on clk edges where the block advances.
- frame_start period: exactly H_TOTAL×V_TOTAL advances. line_start period: H_TOTAL advances.
- Simultaneous H and V wrap at (H_TOTAL-1, V_TOTAL-1): both counters go to 0 in the same cycle.

## Configuration
- VIDEO_TIMING_CE_EN defined: the ce port exists. The block advances only on clk edges with ce = 1. With ce = 0, all outputs hold, and strobes stay at their current value for the duration of the hold. This allows running from a faster system clock.
- VIDEO_TIMING_CE_EN undefined: there is no ce port, and the block advances on every clk edge.

## Test plan
- Reset check: hold rst for 3 cycles → hcount = 1055, vcount = 627, blank = 1, hsync = vsync = 1'b0 (defaults), strobes 0. Release rst → next cycle shows (0, 0) with frame_start = line_start = active = 1.
- Horizontal decode, defaults: active = 1 for hcount 0..799. hsync = 1 exactly for hcount 840..967 (128 cycles). blank = 1 for hcount 800..1055.
- Wrap: hcount 1055 → 0 with vcount 0 → 1. From (1055, 627), the next cycle is (0, 0) with frame_start = 1. There are exactly 663168 cycles between frame_start pulses.
- Vertical decode: vsync = 1 for the entire span of lines 601..604 and 0 elsewhere. blank = 1 for all of lines 600..627.
- Polarity: H_POL = 0, V_POL = 0 → hsync = 0 only in hcount 840..967, vsync = 0 only in lines 601..604, and reset values are hsync = vsync = 1.
- With VIDEO_TIMING_CE_EN, ce = 1 every 4th cycle: outputs change only on ce cycles and the frame period is 4×663168 clks. Asserting rst mid-line with ce = 0 still loads the reset values next edge.
